// File: rtl/button_conditioner_if.sv
// Signal bundle between the push-button pads and the stopwatch logic.
// All outputs are level/pulse signals in the clk domain; there is no valid/ready handshake.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0]   btn_raw;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic [NUM_BTN-1:0]   btn_release;
  logic [NUM_BTN-1:0]   btn_long;
  logic [NUM_BTN-1:0]   btn_repeat;
  logic [3*NUM_BTN-1:0] state_dbg;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_repeat,
    input  state_dbg
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_repeat,
    output state_dbg
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and classifies each push-button independently,
// producing a registered level plus single-cycle press/release/long/repeat pulses.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic               clk,
  input  logic               reset,
  button_conditioner_if.slave btn
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEB_P = 3'd1,
    HELD  = 3'd2,
    LONG  = 3'd3,
    DEB_R = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] long_q, long_d;
  logic [NUM_BTN-1:0] repeat_q, repeat_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= btn.btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Release detection takes priority over timer expiry, so no long/repeat
  // pulse can fire once the pad has dropped.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    level_d   = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) state_d[i] = DEB_P;
        end
        DEB_P: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = DEB_R;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i] = LONG;
            cnt_d[i]   = '0;
            long_d[i]  = 1'b1;
          end
        end
        LONG: begin
          if (!sync2_q[i]) begin
            state_d[i] = DEB_R;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REP_LAST) begin
            cnt_d[i]    = '0;
            repeat_d[i] = 1'b1;
          end
        end
        DEB_R: begin
          if (sync2_q[i]) begin
            // Bounce during release: stay pressed and restart the long timer.
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i]   = IDLE;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
            level_d[i]   = 1'b0;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_long    = long_q;
  assign btn.btn_repeat  = repeat_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_dbg
    assign btn.state_dbg[3*g +: 3] = state_q[g];
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timers
// (DEBOUNCE=4, LONG=10, REPEAT=3); cycle n counts edges after the stimulus edge 0.
module tb_button_conditioner;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  button_conditioner_if #(.NUM_BTN(4)) bif ();

  button_conditioner #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .CNT_W          (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bif)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bif.btn_raw = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    logic [3:0] el, ep;
    bif.btn_raw = 4'hF;
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_hold: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want all 0",
               bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat);
    end
    n_vec++;
    if (bif.state_dbg !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got state_dbg=%h, want 000", bif.state_dbg);
    end
    reset = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      el = (n >= 7) ? 4'hF : 4'h0;
      ep = (n == 7) ? 4'hF : 4'h0;
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, 4'h0, 4'h0, 4'h0}) begin
        n_err++;
        $display("FAIL reset_release cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=0 lng=0 rpt=0",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat, el, ep);
      end
    end
  endtask

  task automatic test_press_release();
    logic [3:0] el, ep, er, eg, et;
    do_reset();
    bif.btn_raw = 4'h1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      el = (n >= 7 && n < 27) ? 4'h1 : 4'h0;
      ep = (n == 7)  ? 4'h1 : 4'h0;
      er = (n == 27) ? 4'h1 : 4'h0;
      eg = (n == 17) ? 4'h1 : 4'h0;
      et = (n == 20) ? 4'h1 : 4'h0;
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, er, eg, et}) begin
        n_err++;
        $display("FAIL press_release cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=%h lng=%h rpt=%h",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat,
                 el, ep, er, eg, et);
      end
      if (n == 20) bif.btn_raw = 4'h0;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] el, ep, er;
    do_reset();
    bif.btn_raw = 4'h2;
    for (int n = 1; n <= 34; n++) begin
      tick();
      el = (n >= 15 && n < 29) ? 4'h2 : 4'h0;
      ep = (n == 15) ? 4'h2 : 4'h0;
      er = (n == 29) ? 4'h2 : 4'h0;
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, er, 4'h0, 4'h0}) begin
        n_err++;
        $display("FAIL bounce cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=%h lng=0 rpt=0",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat,
                 el, ep, er);
      end
      case (n)
        2, 6, 18, 22: bif.btn_raw = 4'h0;
        4, 8, 20:     bif.btn_raw = 4'h2;
        default: ;
      endcase
    end
    bif.btn_raw = 4'h0;
  endtask

  task automatic test_long_repeat();
    logic [3:0] el, ep, er, eg, et;
    do_reset();
    bif.btn_raw = 4'h4;
    for (int n = 1; n <= 36; n++) begin
      tick();
      el = (n >= 7 && n < 32) ? 4'h4 : 4'h0;
      ep = (n == 7)  ? 4'h4 : 4'h0;
      er = (n == 32) ? 4'h4 : 4'h0;
      eg = (n == 17) ? 4'h4 : 4'h0;
      et = (n == 20 || n == 23 || n == 26) ? 4'h4 : 4'h0;
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, er, eg, et}) begin
        n_err++;
        $display("FAIL long_repeat cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=%h lng=%h rpt=%h",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat,
                 el, ep, er, eg, et);
      end
      if (n == 25) bif.btn_raw = 4'h0;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] el, ep, eg;
    do_reset();
    bif.btn_raw = 4'h8;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n <= 18) begin
        el = (n >= 7)  ? 4'h8 : 4'h0;
        ep = (n == 7)  ? 4'h8 : 4'h0;
        eg = (n == 17) ? 4'h8 : 4'h0;
      end else begin
        el = (n >= 26) ? 4'h8 : 4'h0;
        ep = (n == 26) ? 4'h8 : 4'h0;
        eg = 4'h0;
      end
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, 4'h0, eg, 4'h0}) begin
        n_err++;
        $display("FAIL reset_mid_hold cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=0 lng=%h rpt=0",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat,
                 el, ep, eg);
      end
      if (n == 18) begin
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat} !== 20'h0) begin
          n_err++;
          $display("FAIL async_reset: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want all 0",
                   bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat);
        end
      end
      if (n == 19) reset = 1'b1;
    end
    bif.btn_raw = 4'h0;
  endtask

  task automatic test_independence();
    logic [3:0] el, ep, er, eg;
    do_reset();
    bif.btn_raw = 4'h2;
    for (int n = 1; n <= 26; n++) begin
      tick();
      el = {2'b00, (n >= 7 && n < 17), (n >= 15)};
      ep = {2'b00, (n == 7), (n == 15)};
      er = {2'b00, (n == 17), 1'b0};
      eg = {3'b000, (n == 25)};
      n_vec++;
      if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat}
          !== {el, ep, er, eg, 4'h0}) begin
        n_err++;
        $display("FAIL independence cyc %0d: got lvl=%h prs=%h rel=%h lng=%h rpt=%h, want lvl=%h prs=%h rel=%h lng=%h rpt=0",
                 n, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long, bif.btn_repeat,
                 el, ep, er, eg);
      end
      if (n == 8)  bif.btn_raw[0] = 1'b1;
      if (n == 10) bif.btn_raw[1] = 1'b0;
    end
    bif.btn_raw = 4'h0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bif.btn_raw = '0;
    test_reset();
    test_press_release();
    test_bounce();
    test_long_repeat();
    test_reset_mid_hold();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end for the stopwatch board's push-buttons (B1, B2, start, set). It synchronises the raw asynchronous pad levels, debounces each button independently, and emits single-cycle press, release, long-press and auto-repeat pulses in the clk domain. These pulses feed the keypad digit-entry logic and the stopwatch top in place of raw pad signals. Bounce and metastability are removed before any counter or control module sees a button.

Parameters:
NUM_BTN, 4, number of independent buttons (bit 0 = B1, 1 = B2, 2 = start, 3 = set)
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a level change (10 ms at 50 MHz)
LONG_CYCLES, 50000000, held time after an accepted press before long-press fires (1 s)
REPEAT_CYCLES, 10000000, auto-repeat period while in long-press (200 ms)
CNT_W, 26, per-button timer width; must hold max(DEBOUNCE, LONG, REPEAT)-1

Ports:
clk  in  1  system clock (FPGA board clock)
reset  in  1  asynchronous, active-low reset
btn_raw  in  NUM_BTN  raw button pad levels, 1 = pressed, asynchronous
btn_level  out  NUM_BTN  debounced level, 1 = pressed
btn_press  out  NUM_BTN  1-cycle pulse on accepted press
btn_release  out  NUM_BTN  1-cycle pulse on accepted release
btn_long  out  NUM_BTN  1-cycle pulse when held LONG_CYCLES past the press
btn_repeat  out  NUM_BTN  1-cycle pulse every REPEAT_CYCLES while in long-press

Behaviour:
- Reset (reset=0, async): synchroniser flops, state, timers and all outputs clear to 0; state = IDLE. Release is synchronous to clk.
- Per-button 2-flop synchroniser; FSM samples s = second flop. Buttons are fully independent; all outputs are registered.
- States: IDLE, DEB_P, HELD, LONG, DEB_R; one CNT_W timer per button.
- IDLE: s=1 -> DEB_P, cnt=0.
- DEB_P: s=0 -> IDLE (glitch rejected, no pulse). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, btn_press=1 for one cycle, btn_level=1. Otherwise cnt++.
- HELD: s=0 -> DEB_R, cnt=0. cnt==LONG_CYCLES-1 -> LONG, cnt=0, btn_long pulse. Otherwise cnt++.
- LONG: s=0 -> DEB_R, cnt=0. cnt==REPEAT_CYCLES-1 -> btn_repeat pulse, cnt=0. Otherwise cnt++. Repeats continue indefinitely and the timer wraps at REPEAT_CYCLES-1.
- DEB_R: s=1 -> HELD, cnt=0. The long timer restarts; no press pulse; btn_level stays 1. s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_release pulse, btn_level=0. Otherwise cnt++.
- Latency: raw rises and stays high -> btn_press high during the cycle after rising edge DEBOUNCE_CYCLES+3 (2 sync + 1 entry + DEBOUNCE_CYCLES-1 counts + register). Release latency is identical.
- btn_long and btn_repeat never both pulse in the same cycle. The first repeat comes REPEAT_CYCLES after btn_long.
- Pulse and level changes happen only on state transitions; a pulse never lasts more than one cycle.
- Simultaneous presses on different buttons are processed in parallel with no priority.
- Reset mid-debounce or mid-hold: everything clears and no release pulse is emitted. A button still held after reset release is re-debounced from IDLE and gives a fresh press.
- Timer counts never exceed the relevant limit-1 (no overflow for legal parameters).

Test Plan:
(Params for bench: DEBOUNCE=4, LONG=10, REPEAT=3, NUM_BTN=4.)
1. Reset: assert reset=0 with btn_raw=4'hF -> all outputs 0; release reset, hold raw -> btn_press=4'hF pulses together at edge 7 after release, btn_level=4'hF.
2. Clean press/release on bit0: raw high at edge 0 -> btn_press[0] high for exactly one cycle after edge 7. Raw low at edge 20 -> btn_release[0] pulse after edge 27, btn_level[0]=0.
3. Bounce: bit1 toggles 1,0,1,0 every 2 cycles then stays 1 -> exactly one btn_press[1] pulse, 4 stable samples after the last rising bounce. Release bounce of 1-2 cycles -> no extra press and no early release.
4. Long/repeat: hold bit2 -> btn_press, then btn_long 10 cycles later, then btn_repeat every 3 cycles (3 pulses over 9 cycles). Release -> btn_release; no repeat after DEB_R is entered.
5. Reset mid-hold: bit3 in LONG, pulse reset low for 1 cycle -> outputs 0, no release pulse; raw still high -> new btn_press after 7 edges.
6. Independence: bit0 pressed while bit1 in DEB_R -> bit0 press pulse unaffected, bit1 release at its own scheduled cycle.
